// File: rtl/mux_nto1_rr_cond.sv
// rtl/mux_nto1_rr_cond.sv - N-to-1 valid-qualified mux with selector or round-robin choice, registered output
module mux_nto1_rr_cond #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         selector,
    input  logic [NUM_CH-1:0]        valid_in,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0]        grant,
    output logic                     validout,
    output logic [DATA_W-1:0]        dataout,
    output logic [SEL_W-1:0]         ch_out
);

    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  scan_idx;
    logic [SEL_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;
    logic              rr_found;
    logic              sel_ok;
    logic              gnt_any;
    int                scan;

    // First valid channel at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        scan     = 0;
        scan_idx = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            scan = int'(rr_ptr) + off;
            if (scan >= NUM_CH) begin
                scan = scan - NUM_CH;
            end
            scan_idx = SEL_W'(scan);
            if (!rr_found && valid_in[scan_idx]) begin
                rr_found = 1'b1;
                rr_idx   = scan_idx;
            end
        end
    end

    // A selector beyond the last channel never grants.
    always_comb begin
        sel_ok = 1'b0;
        if (int'(selector) < NUM_CH) begin
            sel_ok = valid_in[selector];
        end
    end

    always_comb begin
        gnt_any  = reset_L && (mode ? rr_found : sel_ok);
        gnt_idx  = mode ? rr_idx : selector;
        grant    = gnt_any ? (NUM_CH'(1) << gnt_idx) : '0;
        gnt_data = data_in[gnt_idx*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            validout <= 1'b0;
            dataout  <= '0;
            ch_out   <= '0;
            rr_ptr   <= '0;
        end else begin
            if (gnt_any) begin
                validout <= 1'b1;
                dataout  <= gnt_data;
                ch_out   <= gnt_idx;
            end else begin
                validout <= 1'b0;
                dataout  <= '0;
                ch_out   <= '0;
            end
            if (mode && rr_found) begin
                rr_ptr <= (rr_idx == SEL_W'(NUM_CH - 1)) ? '0 : rr_idx + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr_cond.sv
// tb/tb_mux_nto1_rr_cond.sv - scoreboard bench for mux_nto1_rr_cond at NUM_CH=4/DATA_W=8 and NUM_CH=3/DATA_W=16
module tb_mux_nto1_rr_cond;

    typedef struct {
        bit          v;
        logic [15:0] d;
        int          ch;
    } exp_t;

    logic        clk;
    logic        reset_L;
    logic        mode;
    logic [1:0]  selector;
    logic [3:0]  valid_in;
    logic [31:0] data_a;
    logic [47:0] data_b;
    logic [3:0]  grant_a;
    logic [2:0]  grant_b;
    logic        validout_a, validout_b;
    logic [7:0]  dataout_a;
    logic [15:0] dataout_b;
    logic [1:0]  ch_out_a, ch_out_b;

    int   errors = 0;
    int   checks = 0;
    int   rr_a = 0;
    int   rr_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    mux_nto1_rr_cond #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) dut_a (
        .clk(clk), .reset_L(reset_L), .mode(mode), .selector(selector),
        .valid_in(valid_in), .data_in(data_a), .grant(grant_a),
        .validout(validout_a), .dataout(dataout_a), .ch_out(ch_out_a)
    );

    mux_nto1_rr_cond #(.DATA_W(16), .NUM_CH(3), .SEL_W(2)) dut_b (
        .clk(clk), .reset_L(reset_L), .mode(mode), .selector(selector),
        .valid_in(valid_in[2:0]), .data_in(data_b), .grant(grant_b),
        .validout(validout_b), .dataout(dataout_b), .ch_out(ch_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: index of the channel taken this cycle, or -1 for none.
    function automatic int pick(input int n, input bit m, input int sel, input logic [3:0] v, input int rr);
        int c;
        if (!m) begin
            if (sel < n && v[sel]) return sel;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            c = (rr + k) % n;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Called at a negedge; drives one cycle of stimulus and returns at the next negedge.
    task automatic step(input bit m, input logic [1:0] s, input logic [3:0] v,
                        input logic [31:0] da, input logic [47:0] db);
        int   ga, gb;
        exp_t e;
        mode = m; selector = s; valid_in = v; data_a = da; data_b = db;
        #1;
        ga = pick(4, m, int'(s), v, rr_a);
        gb = pick(3, m, int'(s), {1'b0, v[2:0]}, rr_b);
        chk("grant_a", 32'(grant_a), (ga < 0) ? 32'd0 : (32'd1 << ga));
        chk("grant_b", 32'(grant_b), (gb < 0) ? 32'd0 : (32'd1 << gb));
        e.v = 1'b0; e.d = '0; e.ch = 0;
        if (ga >= 0) begin
            e.v = 1'b1; e.d = 16'(da[ga*8 +: 8]); e.ch = ga;
            if (m) rr_a = (ga + 1) % 4;
        end
        q_a.push_back(e);
        e.v = 1'b0; e.d = '0; e.ch = 0;
        if (gb >= 0) begin
            e.v = 1'b1; e.d = db[gb*16 +: 16]; e.ch = gb;
            if (m) rr_b = (gb + 1) % 3;
        end
        q_b.push_back(e);
        @(negedge clk);
    endtask

    task automatic rstep(input bit m, input logic [1:0] s, input logic [3:0] v);
        step(m, s, v, $urandom, 48'({$urandom, $urandom}));
    endtask

    // Monitor: every output cycle is matched against the oldest expected word.
    always @(posedge clk) begin
        #3;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            chk("validout_a", 32'(validout_a), 32'(ea.v));
            chk("dataout_a", 32'(dataout_a), 32'(ea.d[7:0]));
            chk("ch_out_a", 32'(ch_out_a), ea.ch);
        end else begin
            chk("idle_validout_a", 32'(validout_a), 32'd0);
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            chk("validout_b", 32'(validout_b), 32'(eb.v));
            chk("dataout_b", 32'(dataout_b), 32'(eb.d));
            chk("ch_out_b", 32'(ch_out_b), eb.ch);
        end else begin
            chk("idle_validout_b", 32'(validout_b), 32'd0);
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_validout_a"}, 32'(validout_a), 32'd0);
        chk({tag, "_dataout_a"}, 32'(dataout_a), 32'd0);
        chk({tag, "_ch_out_a"}, 32'(ch_out_a), 32'd0);
        chk({tag, "_grant_a"}, 32'(grant_a), 32'd0);
        chk({tag, "_validout_b"}, 32'(validout_b), 32'd0);
        chk({tag, "_grant_b"}, 32'(grant_b), 32'd0);
    endtask

    initial begin
        reset_L = 1'b0; mode = 1'b1; selector = '0; valid_in = 4'hF;
        data_a = 32'h1234_5678; data_b = 48'h1111_2222_3333;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset_L = 1'b1;

        // First round-robin grant after reset goes to channel 0.
        rstep(1'b1, 2'd0, 4'hF);
        chk("first_rr_ch", 32'(ch_out_a), 32'd0);

        step(1'b0, 2'd2, 4'b0100, 32'hDDCC_BBAA, 48'hA5A5_C3C3_0F0F);
        chk("sel2_valid", 32'(validout_a), 32'd1);
        chk("sel2_data", 32'(dataout_a), 32'hCC);
        chk("sel2_ch", 32'(ch_out_a), 32'd2);
        chk("sel2_data_b", 32'(dataout_b), 32'hA5A5);

        rstep(1'b0, 2'd1, 4'b0101);
        chk("sel_invalid_valid", 32'(validout_a), 32'd0);
        chk("sel_invalid_data", 32'(dataout_a), 32'd0);

        rstep(1'b1, 2'd0, 4'b1000);
        for (int i = 0; i < 8; i++) begin
            rstep(1'b1, 2'($urandom), 4'hF);
            chk("rr_fair_valid", 32'(validout_a), 32'd1);
            chk("rr_fair_ch", 32'(ch_out_a), 32'(i % 4));
        end

        rstep(1'b1, 2'd0, 4'b1010);
        chk("rr_skip_ch1", 32'(ch_out_a), 32'd1);
        rstep(1'b1, 2'd0, 4'b1010);
        chk("rr_skip_ch3", 32'(ch_out_a), 32'd3);
        rstep(1'b1, 2'd0, 4'b0000);
        chk("rr_none_valid", 32'(validout_a), 32'd0);
        rstep(1'b1, 2'd0, 4'hF);
        chk("rr_held_ch0", 32'(ch_out_a), 32'd0);

        rstep(1'b1, 2'd0, 4'b0010);
        repeat (3) rstep(1'b0, 2'd0, 4'hF);
        rstep(1'b1, 2'd0, 4'hF);
        chk("mode_switch_ch2", 32'(ch_out_a), 32'd2);

        rstep(1'b0, 2'd3, 4'hF);
        chk("sel3_nch3_valid", 32'(validout_b), 32'd0);
        chk("sel3_nch4_ch", 32'(ch_out_a), 32'd3);

        for (int i = 0; i < 300; i++) begin
            rstep(1'($urandom), 2'($urandom), 4'($urandom));
        end

        rstep(1'b1, 2'd0, 4'hF);
        chk("pre_reset_valid", 32'(validout_a), 32'd1);
        reset_L = 1'b0;
        #1;
        check_zero("async_reset");
        q_a.delete(); q_b.delete();
        rr_a = 0; rr_b = 0;
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        rstep(1'b1, 2'd0, 4'hF);
        chk("post_reset_ch0", 32'(ch_out_a), 32'd0);

        for (int i = 0; i < 200; i++) begin
            rstep(1'($urandom), 2'($urandom), 4'($urandom));
        end

        chk("queue_a_drained", 32'(q_a.size()), 32'd0);
        chk("queue_b_drained", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_nto1_rr_cond.md
Name: mux_nto1_rr_cond

Overview:
Parametrised N-to-1 multiplexer with valid qualification and a registered output. It generalises the team's fixed-width 2:1 valid-qualified mux in three ways: configurable width, configurable channel count, and a second selection mode. In that mode a round-robin arbiter chooses among valid inputs instead of the external selector. It sits between parallel lane sources and the single downstream datapath, and returns a per-channel grant so sources know when their word was taken.

Parameters:
DATA_W, 8, width of each data channel in bits
NUM_CH, 4, number of input channels; legal range 2..16
SEL_W, 2, selector and channel-index width; must equal ceil(log2(NUM_CH))

Ports:
clk  input  1  rising-edge clock
reset_L  input  1  asynchronous active-low reset
mode  input  1  0 = external selector drives choice; 1 = round-robin over valid inputs
selector  input  SEL_W  channel index, used only when mode=0
valid_in  input  NUM_CH  per-channel valid; bit i qualifies channel i
data_in  input  NUM_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W]
grant  output  NUM_CH  combinational one-hot; the channel accepted at the coming clk edge
validout  output  1  registered; dataout holds an accepted word
dataout  output  DATA_W  registered selected data
ch_out  output  SEL_W  registered index of the channel carried in dataout

Behaviour:
- Reset: while reset_L=0, asynchronously force validout=0, dataout=0, ch_out=0, and internal rr_ptr=0. grant=0 while reset is asserted. On release, normal operation starts at the first rising edge.
- Latency: exactly 1 cycle. Channel k accepted at edge t (grant[k]=1 before t) appears on dataout/ch_out with validout=1 after edge t.
- Acceptance per cycle: at most one channel, so grant is zero or one-hot.
- mode=0:
  - If selector < NUM_CH and valid_in[selector]=1, then grant[selector]=1.
  - If the selected channel is invalid, or selector >= NUM_CH (possible when NUM_CH is not a power of two), then grant=0.
  - rr_ptr is not modified in mode 0.
- mode=1:
  - Search channels rr_ptr, rr_ptr+1, ... modulo NUM_CH. The first channel with valid_in=1 is granted.
  - On a grant of k, rr_ptr <= (k+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  - If no channel is valid, grant=0 and rr_ptr is unchanged.
- Output register at each edge:
  - If any grant: validout<=1, dataout<=granted data, ch_out<=granted index.
  - Otherwise: validout<=0, dataout<=0, ch_out<=0. Data is never held stale.
- Mode switch: mode is sampled each cycle and the new mode governs the very next edge. There is no pipeline flush. rr_ptr survives mode-0 intervals.
- Data on channels whose valid_in=0 never reaches dataout, including X values.
- Reset mid-stream: an in-flight output word is discarded immediately (validout drops asynchronously). Round-robin restarts at channel 0.
- No backpressure: the downstream consumer must accept every validout cycle.

Test Plan:
- Reset check: assert reset_L=0 mid-transfer with validout=1 -> validout, dataout and ch_out go to 0 without waiting for a clk edge. First mode=1 grant after release goes to channel 0 when all channels are valid.
- Selector mode, NUM_CH=4, DATA_W=8: mode=0, data_in={8'hDD,8'hCC,8'hBB,8'hAA}, valid_in=4'b0100, selector=2 -> grant=4'b0100 that cycle, and the next cycle shows validout=1, dataout=8'hCC, ch_out=2.
- Selector on an invalid channel: selector=1 with valid_in[1]=0 -> grant=0, and the next cycle shows validout=0, dataout=0.
- Round-robin fairness: mode=1, valid_in=4'b1111 held for 8 cycles -> ch_out sequence 0,1,2,3,0,1,2,3 and validout=1 on every output cycle.
- Round-robin skip and wrap: after a grant on ch3 (so rr_ptr=0), apply valid_in=4'b1010 -> grant ch1 then ch3; then valid_in=4'b0000 -> validout=0 with rr_ptr held at 0.
- Mode switch plus parameter sweep:
  - With rr_ptr=2, run mode=0 with selector=0 for 3 cycles, then mode=1 with all valid -> next grant is ch2.
  - Repeat the directed set with NUM_CH=3, SEL_W=2, DATA_W=16; selector=3 -> grant=0.
